// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: command codes, address width and FSM states shared with the CPU-side SPI memory controller.
package spi_mem_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int         SPI_ADDR_BITS = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: two-flop synchronizer for an asynchronous pin plus an edge register producing one-cycle rise/fall strobes.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    // Stages 0 and 1 resolve metastability; stage 2 holds the previous synchronized value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], pin_i};
    end

    assign q_o    = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: 23LC-style SPI serial RAM target (READ 0x03 / WRITE 0x02, 24-bit address) over an internal byte array.
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic miso,
    output logic busy,
    output logic cmd_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic                     sclk_s_unused;
    logic                     sclk_rise;
    logic                     sclk_fall;
    logic                     cs_s;
    logic                     cs_rise_unused;
    logic                     cs_fall_unused;
    logic [1:0]               mosi_q;
    logic                     mosi_s;

    state_e                   state_q;
    logic [7:0]               cmd_q;
    logic [4:0]               cnt_q;
    logic [6:0]               rx_q;
    logic [7:0]               tx_q;
    logic [SPI_ADDR_BITS-1:0] addr_q;
    logic                     miso_q;
    logic                     busy_q;
    logic                     cmd_err_q;
    logic                     cs_seen_high_q;

    logic [7:0]               mem_q [DEPTH_BYTES];

    logic [7:0]               rx_byte_d;
    logic [SPI_ADDR_BITS-1:0] addr_shift_d;
    logic [SPI_ADDR_BITS-1:0] addr_inc_d;
    logic [AW-1:0]            rd_idx_d;
    logic [7:0]               rd_data_d;
    logic                     wr_en_d;

    spi_pin_sync u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (sclk),
        .q_o    (sclk_s_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_pin_sync u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (cs_n),
        .q_o    (cs_s),
        .rise_o (cs_rise_unused),
        .fall_o (cs_fall_unused)
    );

    // mosi only needs to line up with the sclk strobes, so it gets the same two-flop delay without an edge stage.
    always_ff @(posedge clk) begin
        if (rst) mosi_q <= '0;
        else     mosi_q <= {mosi_q[0], mosi};
    end

    assign mosi_s = mosi_q[1];

    // Next-value helpers: completed rx byte, shifted address, incremented address and the array read index.
    always_comb begin
        rx_byte_d    = {rx_q, mosi_s};
        addr_shift_d = {addr_q[SPI_ADDR_BITS-2:0], mosi_s};
        addr_inc_d   = addr_q + 24'd1;
        rd_idx_d     = (state_q == ST_ADDR) ? addr_shift_d[AW-1:0] : addr_inc_d[AW-1:0];
        rd_data_d    = mem_q[rd_idx_d];
        wr_en_d      = !rst && !cs_s && sclk_rise && state_q == ST_WRITE && cnt_q[2:0] == 3'd7;
    end

    // Byte array write port; a deselect seen in the same cycle as the 8th bit suppresses the write.
    always_ff @(posedge clk) begin
        if (wr_en_d) mem_q[addr_q[AW-1:0]] <= rx_byte_d;
    end

    // Protocol FSM; deselect has priority over every state, and a reset leaves it idle until cs_n has been seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            cnt_q          <= '0;
            rx_q           <= '0;
            tx_q           <= '0;
            addr_q         <= '0;
            miso_q         <= 1'b0;
            busy_q         <= 1'b0;
            cmd_err_q      <= 1'b0;
            cs_seen_high_q <= 1'b0;
        end else if (cs_s) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            cnt_q          <= '0;
            rx_q           <= '0;
            tx_q           <= '0;
            addr_q         <= '0;
            miso_q         <= 1'b0;
            busy_q         <= 1'b0;
            cs_seen_high_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_seen_high_q) begin
                        state_q <= ST_CMD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_q  <= rx_byte_d[6:0];
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_q <= '0;
                            if (rx_byte_d == SPI_CMD_READ || rx_byte_d == SPI_CMD_WRITE) begin
                                cmd_q   <= rx_byte_d;
                                state_q <= ST_ADDR;
                            end else begin
                                cmd_err_q <= 1'b1;
                                state_q   <= ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_q <= addr_shift_d;
                        cnt_q  <= cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            cnt_q <= '0;
                            if (cmd_q == SPI_CMD_READ) begin
                                state_q <= ST_READ;
                                tx_q    <= rd_data_d;
                            end else begin
                                state_q <= ST_WRITE;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (sclk_fall) begin
                        miso_q <= tx_q[7];
                        tx_q   <= {tx_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_q <= {2'b00, cnt_q[2:0] + 3'd1};
                        if (cnt_q[2:0] == 3'd7) begin
                            addr_q <= addr_inc_d;
                            tx_q   <= rd_data_d;
                        end
                    end
                end
                ST_WRITE: begin
                    if (sclk_rise) begin
                        rx_q  <= rx_byte_d[6:0];
                        cnt_q <= {2'b00, cnt_q[2:0] + 3'd1};
                        if (cnt_q[2:0] == 3'd7) addr_q <= addr_inc_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign miso    = miso_q;
    assign busy    = busy_q;
    assign cmd_err = cmd_err_q;

endmodule
